// File: rtl/xor_sched_pkg.sv
// xor_sched_pkg: shared types and helpers for the round-robin XOR scheduler
package xor_sched_pkg;
  localparam int MAX_REQ = 16;
  typedef enum logic {ST_EMPTY, ST_FULL} state_t;
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/xor_rr_arb.sv
// xor_rr_arb: rotate-priority pick starting at ptr, wrapping at N_REQ-1
module xor_rr_arb
  import xor_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W = id_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  idx,
  output logic             any_grant
);
  logic [ID_W-1:0] j;
  always_comb begin
    idx = '0;
    any_grant = 1'b0;
    j = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = ID_W'((int'(ptr) + k) % N_REQ);
      if (req[j]) begin
        idx = j;
        any_grant = 1'b1;
      end
    end
  end
  assign gnt = any_grant ? N_REQ'(1) << idx : '0;
endmodule

// File: rtl/xor_rr_sched.sv
// xor_rr_sched: round-robin shared registered XOR; XOR_SCHED_PARITY_EN adds res_par
module xor_rr_sched
  import xor_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DATA_W = 8,
  localparam int ID_W = id_w(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_a,
  input  logic [N_REQ*DATA_W-1:0] req_b,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    res_valid,
  output logic [DATA_W-1:0]       res_data,
  output logic [ID_W-1:0]         res_id,
  input  logic                    res_ready
`ifdef XOR_SCHED_PARITY_EN
  ,
  output logic                    res_par
`endif
);
  state_t state, state_nx;
  logic [ID_W-1:0] ptr, idx;
  logic [N_REQ-1:0] gnt;
  logic any_grant, can_accept, xfer;
  logic [DATA_W-1:0] xor_val;
  xor_rr_arb #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .req(req_valid),
    .ptr(ptr),
    .gnt(gnt),
    .idx(idx),
    .any_grant(any_grant)
  );
  assign can_accept = (state == ST_EMPTY) || res_ready;
  assign req_ready = (can_accept && rst) ? gnt : '0;
  assign xfer = any_grant && can_accept && rst;
  assign xor_val = req_a[int'(idx)*DATA_W +: DATA_W] ^ req_b[int'(idx)*DATA_W +: DATA_W];
  assign res_valid = (state == ST_FULL);
  always_comb begin
    state_nx = xfer ? ST_FULL : (res_ready ? ST_EMPTY : state);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_EMPTY;
    else state <= state_nx;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
      res_data <= '0;
      res_id <= '0;
    end else if (xfer) begin
      ptr <= (idx == ID_W'(N_REQ - 1)) ? '0 : idx + 1'b1;
      res_data <= xor_val;
      res_id <= idx;
    end
  end
`ifdef XOR_SCHED_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) res_par <= 1'b0;
    else if (xfer) res_par <= ^xor_val;
  end
`endif
endmodule

// File: tb/tb_xor_rr_sched.sv
// tb_xor_rr_sched: table-driven vectors with a result scoreboard for xor_rr_sched
module tb_xor_rr_sched;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] req_valid;
  logic [31:0] req_a, req_b;
  logic [3:0] req_ready;
  logic res_valid;
  logic [7:0] res_data;
  logic [1:0] res_id;
  logic res_ready;
`ifdef XOR_SCHED_PARITY_EN
  logic res_par;
`endif
  logic [7:0] a_m [4];
  logic [7:0] b_m [4];
  int n_cmp = 0;
  int n_err = 0;
  typedef struct { logic [1:0] id; logic [7:0] d; } sb_t;
  sb_t q[$];
  typedef struct { logic [3:0] v; logic rr; logic [3:0] rdy; } vec_t;
  vec_t tbl [0:17];

  xor_rr_sched #(.N_REQ(4), .DATA_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_a(req_a),
    .req_b(req_b),
    .req_ready(req_ready),
    .res_valid(res_valid),
    .res_data(res_data),
    .res_id(res_id),
    .res_ready(res_ready)
`ifdef XOR_SCHED_PARITY_EN
    ,
    .res_par(res_par)
`endif
  );

  always #5 clk = ~clk;

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < 4; i++) begin
      req_a[i*8 +: 8] = a_m[i];
      req_b[i*8 +: 8] = b_m[i];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic [3:0] v, input logic rr, input logic [3:0] rdy);
    sb_t e;
    req_valid = v;
    res_ready = rr;
    #2;
    chk("req_ready", 32'(req_ready), 32'(rdy));
    chk("res_valid", 32'(res_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk("res_id", 32'(res_id), 32'(q[0].id));
      chk("res_data", 32'(res_data), 32'(q[0].d));
`ifdef XOR_SCHED_PARITY_EN
      chk("res_par", 32'(res_par), 32'(^q[0].d));
`endif
      if (rr) void'(q.pop_front());
    end
    for (int i = 0; i < 4; i++)
      if (rdy[i] && v[i]) begin
        e.id = 2'(i);
        e.d = a_m[i] ^ b_m[i];
        q.push_back(e);
      end
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl = '{
      '{4'b0000, 1'b1, 4'b0000},
      '{4'b0011, 1'b1, 4'b0001},
      '{4'b0011, 1'b1, 4'b0010},
      '{4'b1111, 1'b1, 4'b0100},
      '{4'b1111, 1'b1, 4'b1000},
      '{4'b1111, 1'b1, 4'b0001},
      '{4'b1111, 1'b1, 4'b0010},
      '{4'b1111, 1'b0, 4'b0000},
      '{4'b1111, 1'b0, 4'b0000},
      '{4'b1111, 1'b0, 4'b0000},
      '{4'b1111, 1'b1, 4'b0100},
      '{4'b0000, 1'b1, 4'b0000},
      '{4'b1000, 1'b0, 4'b1000},
      '{4'b0001, 1'b0, 4'b0000},
      '{4'b0000, 1'b0, 4'b0000},
      '{4'b0000, 1'b1, 4'b0000},
      '{4'b0010, 1'b1, 4'b0010},
      '{4'b0000, 1'b1, 4'b0000}
    };
    for (int i = 0; i < 4; i++) begin
      a_m[i] = 8'h00;
      b_m[i] = 8'h00;
    end
    rst = 1'b0;
    req_valid = 4'b1111;
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rst res_valid", 32'(res_valid), 32'd0);
    chk("rst res_data", 32'(res_data), 32'd0);
    chk("rst res_id", 32'(res_id), 32'd0);
    chk("rst req_ready", 32'(req_ready), 32'd0);
    rst = 1'b1;
    a_m[2] = 8'h3C;
    b_m[2] = 8'h0F;
    step(4'b0100, 1'b1, 4'b0100);
    chk("req2 data", 32'(res_data), 32'h33);
    chk("req2 id", 32'(res_id), 32'd2);
    for (int t = 0; t < 18; t++) begin
      for (int i = 0; i < 4; i++) begin
        a_m[i] = 8'($urandom);
        b_m[i] = 8'($urandom);
      end
      step(tbl[t].v, tbl[t].rr, tbl[t].rdy);
    end
    for (int i = 0; i < 4; i++) begin
      a_m[i] = 8'hA5;
      b_m[i] = 8'h00;
    end
    step(4'b0100, 1'b0, 4'b0100);
    chk("hold A5", 32'(res_data), 32'hA5);
    #2;
    rst = 1'b0;
    #1;
    chk("async rst valid", 32'(res_valid), 32'd0);
    chk("async rst data", 32'(res_data), 32'd0);
    chk("async rst id", 32'(res_id), 32'd0);
    chk("async rst ready", 32'(req_ready), 32'd0);
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(4'b1111, 1'b1, 4'b0001);
    step(4'b0000, 1'b1, 4'b0000);
`ifdef XOR_SCHED_PARITY_EN
    a_m[0] = 8'h01;
    b_m[0] = 8'h02;
    step(4'b0001, 1'b1, 4'b0001);
    chk("par 03", 32'(res_par), 32'd0);
    chk("data 03", 32'(res_data), 32'h03);
    a_m[0] = 8'h01;
    b_m[0] = 8'h00;
    step(4'b0001, 1'b1, 4'b0001);
    chk("par 01", 32'(res_par), 32'd1);
    step(4'b0000, 1'b1, 4'b0000);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
